// File: rtl/multicycle_divider.sv
// -----------------------------------------------------------------------------
// multicycle_divider
//
// Purpose:
//   Iterative restoring divider that produces one quotient bit per clock.
//   Signed operation divides operand magnitudes and fixes the signs at the end.
//   The quotient takes the XOR of the operand signs. The remainder takes the
//   dividend's sign. A new start always wins: it aborts any operation in
//   flight, including one on its final edge.
//
// Handshake:
//   start is a one-cycle request. The operands and is_signed are sampled only
//   on that edge. busy is high from that edge until the completing edge. done
//   pulses for one cycle after the completing edge. quotient, remainder and
//   div_zero are updated on that same edge and hold until the next completion.
//
// Configuration macro:
//   MULTICYCLE_DIVIDER_DIVZERO_FAST_EN
//     When defined, a divide by zero completes on the first iteration edge.
//     When undefined, it runs the full WIDTH iterations and the fast path is
//     not built.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   start       in   begin a divide (also aborts one in progress)
//   is_signed   in   1 = two's-complement, 0 = unsigned
//   dividend    in   [WIDTH] numerator
//   divisor     in   [WIDTH] denominator
//   quotient    out  [WIDTH] registered quotient
//   remainder   out  [WIDTH] registered remainder
//   div_zero    out  last completed operation had divisor == 0
//   busy        out  operation in progress
//   done        out  one-cycle completion pulse
//   o_dbg_state out  FSM state (0 = IDLE, 1 = RUN)
// -----------------------------------------------------------------------------
module multicycle_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             busy,
  output logic             done,
  output logic             o_dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_dvd;      // dividend magnitude; quotient bits shift in at the bottom
  logic [WIDTH-1:0]   r_dvs;      // divisor magnitude
  logic [WIDTH-1:0]   r_rem;      // partial remainder
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_div_zero;
  logic               r_done;

  // Operand magnitudes at the start edge.
  logic               w_dd_neg;
  logic               w_ds_neg;
  logic [WIDTH-1:0]   w_dd_mag;
  logic [WIDTH-1:0]   w_ds_mag;

  assign w_dd_neg = is_signed & dividend[WIDTH-1];
  assign w_ds_neg = is_signed & divisor[WIDTH-1];
  assign w_dd_mag = w_dd_neg ? (~dividend + ONE) : dividend;
  assign w_ds_mag = w_ds_neg ? (~divisor + ONE) : divisor;

  // One restoring step. The partial remainder stays below the divisor, so the
  // shifted value fits in WIDTH+1 bits. The extra top bit of the difference
  // is the borrow.
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_rem_step;
  logic [WIDTH-1:0]   w_quo_step;

  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff     = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_borrow   = w_diff[WIDTH+1];
  assign w_rem_step = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_step = {r_dvd[WIDTH-2:0], ~w_borrow};

  logic               w_last;
  logic [WIDTH-1:0]   w_rem_mag;

`ifdef MULTICYCLE_DIVIDER_DIVZERO_FAST_EN
  // A zero divisor finishes on the first iteration edge. r_dvd has not been
  // shifted yet, so it still holds the dividend magnitude.
  assign w_last    = (r_state == ST_RUN) && ((r_cnt == '0) || r_dz);
  assign w_rem_mag = r_dz ? r_dvd : w_rem_step;
`else
  // With a zero divisor every trial subtract succeeds. The full run therefore
  // leaves an all-ones quotient and the dividend magnitude as the remainder.
  assign w_last    = (r_state == ST_RUN) && (r_cnt == '0);
  assign w_rem_mag = w_rem_step;
`endif

  logic [WIDTH-1:0]   w_q_final;
  logic [WIDTH-1:0]   w_r_final;

  // A divide by zero forces an all-ones quotient. The sign-fixed remainder
  // already equals the original dividend, including the most-negative value.
  assign w_q_final = r_dz    ? {WIDTH{1'b1}} :
                     r_neg_q ? (~w_quo_step + ONE) : w_quo_step;
  assign w_r_final = r_neg_r ? (~w_rem_mag + ONE) : w_rem_mag;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: start has priority over completion
  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = ST_RUN;
    end else if (w_last) begin
      w_state_next = ST_IDLE;
    end
  end

  // Datapath and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_cnt   <= CW'(WIDTH - 1);
        r_dvd   <= w_dd_mag;
        r_dvs   <= w_ds_mag;
        r_rem   <= '0;
        r_neg_q <= w_dd_neg ^ w_ds_neg;
        r_neg_r <= w_dd_neg;
        r_dz    <= (divisor == '0);
      end else if (w_last) begin
        r_quotient  <= w_q_final;
        r_remainder <= w_r_final;
        r_div_zero  <= r_dz;
        r_done      <= 1'b1;
      end else if (r_state == ST_RUN) begin
        r_rem <= w_rem_step;
        r_dvd <= w_quo_step;
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_zero    = r_div_zero;
  assign done        = r_done;
  assign busy        = (r_state == ST_RUN);
  assign o_dbg_state = r_state;

endmodule

// File: doc/multicycle_divider.md
MULTICYCLE_DIVIDER -- requirements
Module: multicycle_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a divide; operands and is_signed are sampled on the same edge.
REQ-005 SHALL have port is_signed  input  1  1 = two's-complement divide, 0 = unsigned divide.
REQ-006 SHALL have port dividend  input  WIDTH  numerator.
REQ-007 SHALL have port divisor  input  WIDTH  denominator.
REQ-008 SHALL have port quotient  output  WIDTH  registered result, held until the next completion.
REQ-009 SHALL have port remainder  output  WIDTH  registered result, held until the next completion.
REQ-010 SHALL have port div_zero  output  1  registered flag: last completed operation had divisor == 0.
REQ-011 SHALL have port busy  output  1  high while an operation is in progress (pipeline stall).
REQ-012 SHALL have port done  output  1  one-cycle pulse: quotient/remainder/div_zero just updated.

Function
REQ-013 SHALL use one-bit-per-cycle restoring division on operand magnitudes: 2-state FSM IDLE/RUN with an iteration counter of ceil(log2(WIDTH)) bits.
REQ-014 SHALL, in signed mode, take the magnitudes of dividend and divisor, negate the quotient when their sign bits differ, and give the remainder the sign of the dividend.
REQ-015 SHALL, in unsigned mode, apply no sign handling.
REQ-016 SHALL sample start at edge E0, enter RUN, and assert busy from E0; iterations occur at edges E1..E_WIDTH.
REQ-017 SHALL, at E_WIDTH, load quotient/remainder/div_zero, deassert busy, and assert done for exactly the following cycle; latency = WIDTH cycles.
REQ-018 SHALL treat start during RUN as abort-and-restart: the new operands are captured, the counter reloads, and no done is issued for the aborted operation.
REQ-019 SHALL let start win when it coincides with the final iteration edge: no done, and the outputs are not updated.
REQ-020 SHALL produce, for signed most-negative / -1, quotient = most-negative value and remainder = 0, with no exception flag.
REQ-021 SHALL produce, for divisor == 0 in either mode, quotient = all ones, remainder = dividend, and div_zero = 1.
REQ-022 SHALL, when start is high in IDLE with busy low, leave quotient/remainder/div_zero unchanged until the new operation completes.
REQ-023 SHALL ignore is_signed, dividend and divisor on all cycles except start cycles.

Reset
REQ-024 SHALL, on reset assertion at any time including mid-operation, immediately force IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_zero = 0, and clear all internal registers.
REQ-025 SHALL, after reset release, accept start on the first rising edge.

Configuration
REQ-026 SHALL recognise macro MULTICYCLE_DIVIDER_DIVZERO_FAST_EN.
REQ-027 SHALL, with the macro defined, complete a divisor == 0 operation at E1: busy is high for one cycle and done pulses after E1, with the REQ-021 results.
REQ-028 SHALL, without the macro, run a divisor == 0 operation the full WIDTH cycles with the REQ-021 results; no fast-path logic is synthesised.

Verification (WIDTH=32)
REQ-029 SHALL check unsigned 100 / 7 -> done 32 cycles after start; quotient = 14, remainder = 2, div_zero = 0.
REQ-030 SHALL check signed 0xFFFFFFF9 / 2 -> quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0.
REQ-031 SHALL check unsigned 5 / 0 -> quotient = 0xFFFFFFFF, remainder = 5, div_zero = 1; done after 1 cycle with the macro, 32 cycles without.
REQ-032 SHALL check start 9/3 then start 50/6 on cycle 10 -> exactly one done, 32 cycles after the second start; quotient = 8, remainder = 2.
REQ-033 SHALL check reset asserted at cycle 5 of 100/7 -> busy, done and all outputs 0 immediately; no later done until a new start.
REQ-034 SHALL check back-to-back starts on cycles 0 and 32 (the final edge) -> no done for the first operation; the second completes normally.
